vx_alu_pack8: RTL

Multi-cycle saturating narrowing unit in the ALU execute stage; produces packed int8x4 operands in the layout consumed by the dot8 unit (byte 0 = element 0, little-endian). Each lane narrows four signed 16-bit halfwords (two from rs1, two from rs2) to 8 bits with signed or unsigned saturation. One shared PE processes one active lane per cycle under an IDLE/BUSY/DONE FSM. Valid/ready handshakes on both sides; the tag passes through unchanged.

---
 rtl/vx_alu_pack8.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/vx_alu_pack8.sv
// Saturating narrowing unit: packs four signed halfwords per lane into int8x4/uint8x4,
// one active lane per cycle through a shared PE, valid/ready on both sides.
module vx_alu_pack8 #(
  parameter int NUM_LANES = 4,
  parameter int TAG_WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      in_uns,
  input  logic [NUM_LANES-1:0]      in_tmask,
  input  logic [NUM_LANES*32-1:0]   in_rs1,
  input  logic [NUM_LANES*32-1:0]   in_rs2,
  input  logic [TAG_WIDTH-1:0]      in_tag,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [NUM_LANES*32-1:0]   out_data,
  output logic [NUM_LANES-1:0]      out_sat,
  output logic [NUM_LANES-1:0]      out_tmask,
  output logic [TAG_WIDTH-1:0]      out_tag
);

  localparam int PW = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t                    state, state_n;
  logic [NUM_LANES*32-1:0]   rs1_q, rs2_q;
  logic                      uns_q;
  logic [PW-1:0]             ptr, first_ptr, next_ptr;
  logic                      first_found, next_found;
  logic                      accept;
  logic [PW+4:0]             lane_ofs;
  logic [63:0]               lane_hw;
  logic [31:0]               lane_res;
  logic                      lane_sat;

  // Returns {clamped, byte}.
  function automatic logic [8:0] sat8(input logic [15:0] h, input logic uns);
    logic signed [15:0] s;
    s = $signed(h);
    if (uns) begin
      if (s < 16'sd0)        return {1'b1, 8'h00};
      else if (s > 16'sd255) return {1'b1, 8'hFF};
      else                   return {1'b0, h[7:0]};
    end else begin
      if (s < -16'sd128)     return {1'b1, 8'h80};
      else if (s > 16'sd127) return {1'b1, 8'h7F};
      else                   return {1'b0, h[7:0]};
    end
  endfunction

  assign accept   = in_valid && in_ready;
  assign lane_ofs = {ptr, 5'd0};

  always_comb begin
    first_ptr   = '0;
    first_found = 1'b0;
    for (int unsigned i = 0; i < NUM_LANES; i++) begin
      if (!first_found && in_tmask[i]) begin
        first_ptr   = PW'(i);
        first_found = 1'b1;
      end
    end
  end

  always_comb begin
    next_ptr   = ptr;
    next_found = 1'b0;
    for (int unsigned i = 0; i < NUM_LANES; i++) begin
      if (!next_found && (i > 32'(ptr)) && out_tmask[i]) begin
        next_ptr   = PW'(i);
        next_found = 1'b1;
      end
    end
  end

  always_comb begin
    logic [8:0] r;
    lane_hw  = {rs2_q[lane_ofs +: 32], rs1_q[lane_ofs +: 32]};
    lane_res = '0;
    lane_sat = 1'b0;
    r        = '0;
    for (int unsigned j = 0; j < 4; j++) begin
      r = sat8(lane_hw[16*j +: 16], uns_q);
      lane_res[8*j +: 8] = r[7:0];
      lane_sat = lane_sat | r[8];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_n;
  end

  // An empty mask still spends one BUSY cycle (no lane write) so latency is max(k,1).
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE: if (in_valid) state_n = S_BUSY;
      S_BUSY: if (!next_found) state_n = S_DONE;
      S_DONE: if (out_ready) state_n = in_valid ? S_BUSY : S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      S_IDLE: in_ready = 1'b1;
      S_DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rs1_q     <= '0;
      rs2_q     <= '0;
      uns_q     <= 1'b0;
      ptr       <= '0;
      out_data  <= '0;
      out_sat   <= '0;
      out_tmask <= '0;
      out_tag   <= '0;
    end else if (accept) begin
      rs1_q     <= in_rs1;
      rs2_q     <= in_rs2;
      uns_q     <= in_uns;
      ptr       <= first_ptr;
      out_data  <= '0;
      out_sat   <= '0;
      out_tmask <= in_tmask;
      out_tag   <= in_tag;
    end else if (state == S_BUSY) begin
      if (out_tmask[ptr]) begin
        out_data[lane_ofs +: 32] <= lane_res;
        out_sat[ptr]             <= lane_sat;
      end
      ptr <= next_ptr;
    end
  end

endmodule
